time_set_controller: RTL

Sequencer for the user time-set flow of the desk alarm clock. Edge-detects debounced buttons, walks a set-hours/set-minutes state machine, holds shadow copies of the field being edited and issues a one-cycle load to the time counter on commit. Owns the 12h/24h mode bit that drives the 12h/24h display converter, and supplies the converter's hour/minute inputs: shadow values while editing, live time otherwise.

---
 rtl/time_set_pkg.sv | 28 ++
 rtl/time_set_controller_button_edge.sv | 26 ++
 rtl/time_set_controller.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/time_set_pkg.sv
// Shared types and limits for the clock time-set flow.
// Pure declarations; no latency or backpressure of its own.
// Field-wrapping helpers used by the edit sequencer.
package time_set_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_SET_HOURS   = 2'd1,
        ST_SET_MINUTES = 2'd2,
        ST_COMMIT      = 2'd3
    } state_t;

    localparam int HOURS_W   = 5;
    localparam int MINUTES_W = 6;

    localparam logic [HOURS_W-1:0]   MAX_HOURS   = 5'd23;
    localparam logic [MINUTES_W-1:0] MAX_MINUTES = 6'd59;

    // The >= form also pulls an out-of-range captured value back to 0.
    function automatic logic [HOURS_W-1:0] next_hours(input logic [HOURS_W-1:0] h);
        return (h >= MAX_HOURS) ? '0 : h + 5'd1;
    endfunction

    function automatic logic [MINUTES_W-1:0] next_minutes(input logic [MINUTES_W-1:0] m);
        return (m >= MAX_MINUTES) ? '0 : m + 6'd1;
    endfunction

endpackage

// File: rtl/time_set_controller_button_edge.sv
// Rising-edge detector for one debounced button level.
// Latency: pulse in the cycle the level is first seen high; no backpressure.
// The first cycle after reset is masked so a level held through reset is not an edge.
module button_edge (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic rise
);

    logic prev;
    logic primed;

    always_ff @(posedge clk) begin
        if (reset) begin
            prev   <= 1'b0;
            primed <= 1'b0;
        end else begin
            prev   <= btn;
            primed <= 1'b1;
        end
    end

    assign rise = btn & ~prev & primed;

endmodule

// File: rtl/time_set_controller.sv
// Time-set sequencer: button edges walk IDLE/SET_HOURS/SET_MINUTES/COMMIT, one-cycle load on commit.
// Latency: edge sampled in cycle N acts in N+1; display mux lags its sources by one cycle; no backpressure.
// Optional AUTO_REPEAT_EN macro enables hold-to-repeat on the increment button.
module time_set_controller
    import time_set_pkg::*;
#(
    parameter int HOLD_STBS    = 4,
    parameter int TIMEOUT_STBS = 80
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_stb,
    input  logic                 i_btn_set,
    input  logic                 i_btn_inc,
    input  logic                 i_btn_fmt,
    input  logic [HOURS_W-1:0]   i_hours,
    input  logic [MINUTES_W-1:0] i_minutes,
    output logic                 o_12h_mode,
    output logic [HOURS_W-1:0]   o_disp_hours,
    output logic [MINUTES_W-1:0] o_disp_minutes,
    output logic                 o_load,
    output logic [HOURS_W-1:0]   o_load_hours,
    output logic [MINUTES_W-1:0] o_load_minutes,
    output logic [MINUTES_W-1:0] o_load_seconds,
    output logic                 o_blink_hours,
    output logic                 o_blink_minutes
);

    localparam int TMO_W = $clog2(TIMEOUT_STBS + 1);

    state_t                 state;
    logic [HOURS_W-1:0]     shadow_hours;
    logic [MINUTES_W-1:0]   shadow_minutes;
    logic [TMO_W-1:0]       idle_cnt;

    logic set_rise, inc_rise, fmt_rise, any_rise;
    logic in_set, timeout_hit, repeat_tick, bump;

    button_edge u_set_edge (.clk(i_clk), .reset(i_reset), .btn(i_btn_set), .rise(set_rise));
    button_edge u_inc_edge (.clk(i_clk), .reset(i_reset), .btn(i_btn_inc), .rise(inc_rise));
    button_edge u_fmt_edge (.clk(i_clk), .reset(i_reset), .btn(i_btn_fmt), .rise(fmt_rise));

    assign any_rise    = set_rise | inc_rise | fmt_rise;
    assign in_set      = (state == ST_SET_HOURS) || (state == ST_SET_MINUTES);
    assign timeout_hit = in_set & i_stb & ~any_rise &
                         (idle_cnt == TMO_W'(TIMEOUT_STBS - 1));

`ifdef AUTO_REPEAT_EN
    localparam int HOLD_W = $clog2(HOLD_STBS + 1);
    logic [HOLD_W-1:0] hold_cnt;

    assign repeat_tick = i_stb & i_btn_inc & (hold_cnt == HOLD_W'(HOLD_STBS));

    // Any state change (set edge or timeout) restarts the hold qualification.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            hold_cnt <= '0;
        end else if (!in_set || !i_btn_inc || set_rise || timeout_hit) begin
            hold_cnt <= '0;
        end else if (i_stb && (hold_cnt != HOLD_W'(HOLD_STBS))) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
        end
    end
`else
    // Without repeat only edges increment; HOLD_STBS is never negative so this stays 0.
    assign repeat_tick = (HOLD_STBS < 0);
`endif

    assign bump = (inc_rise | repeat_tick) & ~set_rise & ~timeout_hit;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            idle_cnt <= '0;
        end else if (!in_set || any_rise || timeout_hit) begin
            idle_cnt <= '0;
        end else if (i_stb) begin
            idle_cnt <= idle_cnt + TMO_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state           <= ST_IDLE;
            shadow_hours    <= '0;
            shadow_minutes  <= '0;
            o_12h_mode      <= 1'b0;
            o_disp_hours    <= '0;
            o_disp_minutes  <= '0;
            o_load          <= 1'b0;
            o_load_hours    <= '0;
            o_load_minutes  <= '0;
            o_load_seconds  <= '0;
            o_blink_hours   <= 1'b0;
            o_blink_minutes <= 1'b0;
        end else begin
            o_load <= 1'b0;
            if (fmt_rise) begin
                o_12h_mode <= ~o_12h_mode;
            end
            o_disp_hours   <= (state == ST_IDLE) ? i_hours   : shadow_hours;
            o_disp_minutes <= (state == ST_IDLE) ? i_minutes : shadow_minutes;

            case (state)
                ST_IDLE: begin
                    if (set_rise) begin
                        state          <= ST_SET_HOURS;
                        shadow_hours   <= i_hours;
                        shadow_minutes <= i_minutes;
                        o_blink_hours  <= 1'b1;
                    end
                end
                ST_SET_HOURS: begin
                    if (timeout_hit) begin
                        state         <= ST_IDLE;
                        o_blink_hours <= 1'b0;
                    end else if (set_rise) begin
                        state           <= ST_SET_MINUTES;
                        o_blink_hours   <= 1'b0;
                        o_blink_minutes <= 1'b1;
                    end else if (bump) begin
                        shadow_hours <= next_hours(shadow_hours);
                    end
                end
                ST_SET_MINUTES: begin
                    if (timeout_hit) begin
                        state           <= ST_IDLE;
                        o_blink_minutes <= 1'b0;
                    end else if (set_rise) begin
                        state           <= ST_COMMIT;
                        o_blink_minutes <= 1'b0;
                        o_load          <= 1'b1;
                        o_load_hours    <= shadow_hours;
                        o_load_minutes  <= shadow_minutes;
                        o_load_seconds  <= '0;
                    end else if (bump) begin
                        shadow_minutes <= next_minutes(shadow_minutes);
                    end
                end
                ST_COMMIT: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
